// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt initiator: CP0 write burst, flush and fetch redirect (optional EXC_TIMER_INT_EN)
module exc_ctrl #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic             mem_stall,
  input  logic [WIDTH-1:0] mem_pc,
  input  logic             mem_in_ds,
  input  logic             exc_adel_if,
  input  logic             exc_ri,
  input  logic             exc_ov,
  input  logic             exc_sys,
  input  logic             exc_bp,
  input  logic             exc_adel_ld,
  input  logic             exc_ades,
  input  logic [WIDTH-1:0] mem_data_addr,
  input  logic             mem_eret,
  input  logic [5:0]       hw_int,
  input  logic [WIDTH-1:0] cp0_status,
  input  logic [WIDTH-1:0] cp0_cause,
  input  logic [WIDTH-1:0] cp0_epc_in,
`ifdef EXC_TIMER_INT_EN
  input  logic [WIDTH-1:0] cp0_count,
  input  logic [WIDTH-1:0] cp0_compare,
  input  logic             compare_wr,
`endif
  output logic [WIDTH-1:0] cp0_we,
  output logic [WIDTH-1:0] cp0_epc,
  output logic [WIDTH-1:0] cp0_badvaddr,
  output logic [4:0]       cp0_exccode,
  output logic             cp0_bd,
  output logic             cp0_exl,
  output logic [5:0]       cp0_hw_int,
  output logic             commit_block,
  output logic             flush,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  input  logic             redirect_ready
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WRITE    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  localparam logic [4:0] EC_INT  = 5'h00;
  localparam logic [4:0] EC_ADEL = 5'h04;
  localparam logic [4:0] EC_ADES = 5'h05;
  localparam logic [4:0] EC_SYS  = 5'h08;
  localparam logic [4:0] EC_BP   = 5'h09;
  localparam logic [4:0] EC_RI   = 5'h0A;
  localparam logic [4:0] EC_OV   = 5'h0C;

  state_t           state_q, state_d;
  logic [5:0]       hw_int_q;
  logic [5:0]       hw_int_eff;
  logic [WIDTH-1:0] epc_q;
  logic [WIDTH-1:0] badvaddr_q;
  logic [4:0]       exccode_q;
  logic             in_ds_q;
  logic             is_eret_q;
  logic             addr_err_q;
  logic [WIDTH-1:0] target_q;

  logic             int_req;
  logic             any_exc;
  logic             accept;
  logic [4:0]       exccode_d;
  logic             addr_err_d;
  logic             is_eret_d;
  logic [WIDTH-1:0] epc_d;
  logic [WIDTH-1:0] badvaddr_d;

  logic unused_ok;
  assign unused_ok = ^{cp0_status[WIDTH-1:16], cp0_status[7:2],
                       cp0_cause[WIDTH-2:10], cp0_cause[7:0]};

`ifdef EXC_TIMER_INT_EN
  logic timer_pend_q;

  // Timer interrupt pending flag: a Compare write clears it even on a match cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_pend_q <= 1'b0;
    end else if (compare_wr) begin
      timer_pend_q <= 1'b0;
    end else if ((cp0_count == cp0_compare) && (cp0_compare != '0)) begin
      timer_pend_q <= 1'b1;
    end
  end

  assign hw_int_eff = {hw_int_q[5] | timer_pend_q, hw_int_q[4:0]};
`else
  assign hw_int_eff = hw_int_q;
`endif

  assign cp0_hw_int = hw_int_eff;

  // Interrupt request from masked pending lines, only with IE set and EXL clear
  always_comb begin
    int_req = cp0_status[0] & ~cp0_status[1] &
              (|(cp0_status[15:8] & {hw_int_eff, cp0_cause[9:8]}));
    any_exc = exc_adel_if | exc_ri | exc_ov | exc_sys | exc_bp | exc_adel_ld | exc_ades;
    accept  = (state_q == S_IDLE) & mem_valid & ~mem_stall & (int_req | any_exc | mem_eret);
  end

  // Event priority: interrupt first, then the exceptions in pipeline order, ERET last
  always_comb begin
    exccode_d  = EC_INT;
    addr_err_d = 1'b0;
    is_eret_d  = 1'b0;
    if (int_req) begin
      exccode_d = EC_INT;
    end else if (exc_adel_if) begin
      exccode_d  = EC_ADEL;
      addr_err_d = 1'b1;
    end else if (exc_ri) begin
      exccode_d = EC_RI;
    end else if (exc_ov) begin
      exccode_d = EC_OV;
    end else if (exc_sys) begin
      exccode_d = EC_SYS;
    end else if (exc_bp) begin
      exccode_d = EC_BP;
    end else if (exc_adel_ld) begin
      exccode_d  = EC_ADEL;
      addr_err_d = 1'b1;
    end else if (exc_ades) begin
      exccode_d  = EC_ADES;
      addr_err_d = 1'b1;
    end else begin
      is_eret_d = 1'b1;
    end
    epc_d      = mem_in_ds ? (mem_pc - WIDTH'(4)) : mem_pc;
    badvaddr_d = exc_adel_if ? mem_pc : mem_data_addr;
  end

  // State, interrupt sampling, event latching and redirect target capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hw_int_q   <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      exccode_q  <= '0;
      in_ds_q    <= 1'b0;
      is_eret_q  <= 1'b0;
      addr_err_q <= 1'b0;
      target_q   <= '0;
    end else begin
      state_q  <= state_d;
      hw_int_q <= hw_int;
      if (accept) begin
        epc_q      <= epc_d;
        badvaddr_q <= badvaddr_d;
        exccode_q  <= exccode_d;
        in_ds_q    <= mem_in_ds;
        is_eret_q  <= is_eret_d;
        addr_err_q <= addr_err_d;
      end
      if (state_q == S_WRITE) begin
        target_q <= is_eret_q ? cp0_epc_in : EXC_VECTOR;
      end
    end
  end

  // Next state and per-state outputs; everything is quiet in IDLE
  always_comb begin
    state_d        = state_q;
    cp0_we         = '0;
    cp0_epc        = '0;
    cp0_badvaddr   = '0;
    cp0_exccode    = '0;
    cp0_bd         = 1'b0;
    cp0_exl        = 1'b0;
    commit_block   = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        commit_block = 1'b1;
        flush        = 1'b1;
        if (is_eret_q) begin
          cp0_we[12] = 1'b1;
          cp0_exl    = 1'b0;
        end else begin
          cp0_we[13]   = 1'b1;
          cp0_we[12]   = 1'b1;
          cp0_exl      = 1'b1;
          cp0_we[14]   = ~cp0_status[1];
          cp0_we[8]    = addr_err_q;
          cp0_bd       = cp0_status[1] ? cp0_cause[WIDTH-1] : in_ds_q;
          cp0_epc      = epc_q;
          cp0_badvaddr = badvaddr_q;
          cp0_exccode  = exccode_q;
        end
        state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        commit_block   = 1'b1;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        if (redirect_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception/interrupt initiator that drives the CP0 write side from the pipeline commit point (MEM stage). It prioritises exceptions, samples interrupts and computes EPC/BD/BadVAddr/ExcCode. It issues a one-cycle CP0 write burst, then flushes the pipeline and hands a redirect PC (exception vector or EPC for ERET) to fetch over a valid/ready handshake.

Parameters:
WIDTH, 32, data/address width
EXC_VECTOR, 32'hBFC00380, general exception entry PC

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_valid  in  1  MEM-stage instruction present
mem_stall  in  1  MEM stage stalled (AXI wait); commit only when 0
mem_pc  in  WIDTH  PC of MEM instruction
mem_in_ds  in  1  instruction is in a branch delay slot
exc_adel_if  in  1  fetch address error
exc_ri  in  1  reserved instruction
exc_ov  in  1  arithmetic overflow
exc_sys  in  1  syscall
exc_bp  in  1  break
exc_adel_ld  in  1  load address error
exc_ades  in  1  store address error
mem_data_addr  in  WIDTH  load/store virtual address
mem_eret  in  1  instruction is ERET
hw_int  in  6  external hardware interrupt lines
cp0_status  in  WIDTH  current Status
cp0_cause  in  WIDTH  current Cause
cp0_epc_in  in  WIDTH  current EPC
cp0_we  out  WIDTH  one-hot-per-register CP0 write strobes (bits 8, 12, 13, 14 used)
cp0_epc  out  WIDTH  EPC write value
cp0_badvaddr  out  WIDTH  BadVAddr write value
cp0_exccode  out  5  ExcCode write value
cp0_bd  out  1  Cause.BD write value
cp0_exl  out  1  Status.EXL write value
cp0_hw_int  out  6  registered hw_int forwarded to CP0
commit_block  out  1  inhibits further MEM commits
flush  out  1  kill all in-flight instructions
redirect_valid  out  1  redirect PC valid
redirect_pc  out  WIDTH  target PC
redirect_ready  in  1  fetch accepts redirect

Behaviour:
- Reset: state IDLE; all outputs 0; internal registers 0.
- hw_int registered once (cp0_hw_int); interrupt request int_req = Status[0] & ~Status[1] & |(Status[15:8] & {cp0_hw_int, cp0_cause[9:8]}).
- Event accepted in IDLE when mem_valid & ~mem_stall & (int_req | any exc_* | mem_eret). Not accepted if mem_valid=0 (interrupt waits).
- Priority (ExcCode): Int 0x00 > AdEL-IF 0x04 > RI 0x0A > Ov 0x0C > Sys 0x08 > Bp 0x09 > AdEL-ld 0x04 > AdES 0x05 > ERET (no code). Exception always wins over ERET on the same instruction.
- Latched on acceptance: epc = mem_in_ds ? mem_pc-4 : mem_pc (mod 2^WIDTH); badvaddr = AdEL-IF ? mem_pc : mem_data_addr; kind (exc/eret).
- FSM: IDLE -> WRITE (cycle after acceptance) -> REDIRECT -> IDLE on redirect_valid & redirect_ready.
- WRITE (exactly 1 cycle): exception: cp0_we[13]=1, cp0_we[12]=1 with cp0_exl=1, cp0_we[14]=1 only if Status[1]=0, cp0_we[8]=1 only for AdEL/AdES. If Status[1]=1 (nested), EPC unchanged and cp0_bd = cp0_cause[31]; otherwise cp0_bd = latched mem_in_ds. ERET: only cp0_we[12] with cp0_exl=0.
- REDIRECT: redirect_valid=1, redirect_pc = EXC_VECTOR (exception) or cp0_epc_in sampled at WRITE (ERET); held stable until ready.
- flush and commit_block = 1 in WRITE and REDIRECT, and through the handshake cycle; 0 in IDLE.
- cp0_we zero in all states except WRITE.
- Latency: acceptance cycle N -> cp0_we cycle N+1 -> redirect_valid from N+2.
- Events while not IDLE are ignored (commit_block guarantees none).
- rst in any state: immediate return to IDLE, outputs 0, no partial write.

Optional Feature:
EXC_TIMER_INT_EN: adds inputs cp0_count[WIDTH], cp0_compare[WIDTH], compare_wr[1]; internal timer_pend set when count==compare and compare!=0, cleared by compare_wr (clear wins). timer_pend is ORed into IP7 (hw_int[5] position) for int_req and cp0_hw_int[5]. Without macro: ports absent, hw_int[5] used unchanged.

Test Plan:
- Status=0x0000FF01, hw_int=6'b000001, mem_valid=1, pc=0x80001000 -> cycle+2 cp0_we bits 12,13,14 set, exccode 0, epc 0x80001000, then redirect_pc 0xBFC00380.
- exc_ov in delay slot, pc=0x80002004, Status[1]=0 -> epc 0x80002000, bd=1, exccode 0x0C, cp0_we[8]=0.
- exc_ades, data_addr=0x80003001 -> cp0_we[8]=1, badvaddr 0x80003001, exccode 0x05.
- mem_eret, cp0_epc_in=0x80004000 -> only cp0_we[12], exl=0, redirect_pc 0x80004000; redirect_ready low 3 cycles -> valid/pc held, flush held.
- Nested: Status[1]=1, exc_sys -> cp0_we[14]=0, bd=cp0_cause[31], exccode 0x08; int pending with Status[1]=1 -> no event.
- rst asserted during REDIRECT -> next cycle all outputs 0, IDLE; exc_ri with mem_stall=1 -> no acceptance until stall drops.
